data_sram_responder: RTL and testbench

- Memory-side responder for the CPU data SRAM port. It serves en/wen/addr/wdata requests from the datapath and returns read data.
- Backed by a word-addressed RAM with byte write enables.
- A programmable wait-state counter drives d_stall, so the datapath's stall path can be exercised with real back-pressure instead of the tied-off d_stall=0.
- Instantiated beside the CPU top in simulation and FPGA bring-up.

---
 rtl/data_sram_responder.sv | 127 ++++++++++++
 tb/tb_data_sram_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word-addressed RAM with byte enables and programmable wait states.
// Define DATA_SRAM_RESPONDER_MMIO_EN to map 0xBFAF_xxxx to MMIO (cycle counter at 0xBFAF_E000).
module data_sram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        d_stall
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] cap_addr;
  logic [3:0]  cap_wen;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH];

  logic                  acc_fire;
  logic [31:0]           acc_addr;
  logic [3:0]            acc_wen;
  logic [31:0]           acc_wdata;
  logic                  acc_write;
  logic [DEPTH_LOG2-1:0] acc_index;
  logic                  ram_hit;
  logic [31:0]           read_word;
  logic                  unused_addr_bits;

  assign d_stall = (state == IDLE && data_sram_en && HAS_WAIT) ||
                   (state == BUSY && cnt != 4'd0);

  // Zero-wait accesses use the live request; waited ones use the copy captured at acceptance.
  always_comb begin
    acc_fire  = !rst && ((state == IDLE && data_sram_en && !HAS_WAIT) ||
                         (state == BUSY && cnt == 4'd0));
    acc_addr  = (state == BUSY) ? cap_addr  : data_sram_addr;
    acc_wen   = (state == BUSY) ? cap_wen   : data_sram_wen;
    acc_wdata = (state == BUSY) ? cap_wdata : data_sram_wdata;
    acc_write = (acc_wen != 4'd0);
    acc_index = acc_addr[DEPTH_LOG2+1:2];
  end

  assign unused_addr_bits = ^{acc_addr[31:DEPTH_LOG2+2], acc_addr[1:0]};

`ifdef DATA_SRAM_RESPONDER_MMIO_EN
  logic [31:0] cycle_cnt;

  // A write to the counter wins over the free-running increment in that cycle.
  always_ff @(posedge clk) begin
    if (rst)
      cycle_cnt <= 32'd0;
    else if (acc_fire && !ram_hit && acc_write && acc_addr[15:0] == 16'hE000)
      cycle_cnt <= acc_wdata;
    else
      cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_comb begin
    ram_hit   = (acc_addr[31:16] != 16'hBFAF);
    read_word = 32'd0;
    if (ram_hit)
      read_word = mem[acc_index];
    else if (acc_addr[15:0] == 16'hE000)
      read_word = cycle_cnt;
  end
`else
  always_comb begin
    ram_hit   = 1'b1;
    read_word = mem[acc_index];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      data_sram_rdata <= 32'd0;
      cap_addr        <= 32'd0;
      cap_wen         <= 4'd0;
      cap_wdata       <= 32'd0;
    end else begin
      if (acc_fire && !acc_write)
        data_sram_rdata <= read_word;
      case (state)
        IDLE: begin
          if (data_sram_en && HAS_WAIT) begin
            cap_addr  <= data_sram_addr;
            cap_wen   <= data_sram_wen;
            cap_wdata <= data_sram_wdata;
            cnt       <= WAIT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
          else
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM contents survive reset; acc_fire is already gated by rst so an aborted write is dropped.
  always_ff @(posedge clk) begin
    if (acc_fire && acc_write && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i])
          mem[acc_index][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: three instances with 0, 2 and 3 wait states.
// Exercises the DATA_SRAM_RESPONDER_MMIO_EN counter when that macro is defined.
module tb_data_sram_responder;

  logic        clk;
  logic        rst      [3];
  logic        en       [3];
  logic [3:0]  wen      [3];
  logic [31:0] addr     [3];
  logic [31:0] wdata    [3];
  logic [31:0] rdata    [3];
  logic        stall    [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] exp_q2 [$];
  logic [2:0]  mon_fire;

  data_sram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_rdata(rdata[0]), .d_stall(stall[0]));

  data_sram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_rdata(rdata[1]), .d_stall(stall[1]));

  data_sram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst[2]), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
    .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]),
    .data_sram_rdata(rdata[2]), .d_stall(stall[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input int k, input logic [31:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic popCompare(input int k, input logic [31:0] actual);
    logic [31:0] e;
    int          sz;
    case (k)
      0: sz = exp_q0.size();
      1: sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    if (sz == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_read dut%0d actual=%h expected=none", k, actual);
    end else begin
      case (k)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      checkOutput($sformatf("rdata_dut%0d", k), actual, e);
    end
  endtask

  // Monitor: a read is accepted on an edge with en=1, d_stall=0, wen=0; rdata is checked just after.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      mon_fire[k] = en[k] && !stall[k] && (wen[k] == 4'd0) && !rst[k];
    #1;
    for (int k = 0; k < 3; k++)
      if (mon_fire[k]) popCompare(k, rdata[k]);
  end

  // Issue one request, hold it while stalled, and check the number of stall cycles.
  task automatic applyStimulus(input int k, input logic [3:0] w, input logic [31:0] a,
                               input logic [31:0] d, input int exp_stalls,
                               input logic [31:0] exp_rd, input bit change_data);
    int stalls;
    @(negedge clk);
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    if (w == 4'd0) pushExpected(k, exp_rd);
    stalls = 0;
    #1;
    while (stall[k] && stalls < 20) begin
      stalls++;
      @(negedge clk);
      if (change_data) wdata[k] = ~d;
      #1;
    end
    checkOutput($sformatf("stall_count_dut%0d_a%h", k, a), stalls, exp_stalls);
  endtask

  task automatic idleCycles(input int k, input int n);
    @(negedge clk);
    en[k] = 1'b0; wen[k] = 4'd0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; wen[k] = 4'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset_rdata_dut%0d", k), rdata[k], 32'd0);
      checkOutput($sformatf("reset_stall_dut%0d", k), {31'd0, stall[k]}, 32'd0);
    end

    // Zero wait states: back-to-back accesses, word-address wrap, low address bits ignored
    applyStimulus(0, 4'hF, 32'h10,   32'hDEADBEEF, 0, 32'h0, 1'b0);
    applyStimulus(0, 4'h0, 32'h10,   32'h0,        0, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 4'hF, 32'h1000, 32'h12345678, 0, 32'h0, 1'b0);
    applyStimulus(0, 4'h0, 32'h0,    32'h0,        0, 32'h12345678, 1'b0);
    applyStimulus(0, 4'h0, 32'h13,   32'h0,        0, 32'hDEADBEEF, 1'b0);
    idleCycles(0, 3);
    #1;
    checkOutput("rdata_hold_dut0", rdata[0], 32'hDEADBEEF);

`ifdef DATA_SRAM_RESPONDER_MMIO_EN
    // Counter loaded at the write edge; the read edge is 5 edges later and sees 0x100 + 4
    applyStimulus(0, 4'hF, 32'hBFAFE000, 32'h100,      0, 32'h0, 1'b0);
    idleCycles(0, 4);
    applyStimulus(0, 4'h0, 32'hBFAFE000, 32'h0,        0, 32'h104, 1'b0);
    applyStimulus(0, 4'h0, 32'h0,        32'h0,        0, 32'h12345678, 1'b0);
    applyStimulus(0, 4'hF, 32'hBFAF0004, 32'hFFFFFFFF, 0, 32'h0, 1'b0);
    applyStimulus(0, 4'h0, 32'hBFAF0004, 32'h0,        0, 32'h0, 1'b0);
`else
    // Without MMIO, 0xBFAF_E000 aliases to RAM word 0
    applyStimulus(0, 4'hF, 32'hBFAFE000, 32'hCAFEF00D, 0, 32'h0, 1'b0);
    applyStimulus(0, 4'h0, 32'hBFAFE000, 32'h0,        0, 32'hCAFEF00D, 1'b0);
    applyStimulus(0, 4'h0, 32'h0,        32'h0,        0, 32'hCAFEF00D, 1'b0);
`endif
    idleCycles(0, 1);

    // Two wait states: stall length, byte enables, captured write data
    applyStimulus(1, 4'hF, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    applyStimulus(1, 4'h0, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b0);
    applyStimulus(1, 4'h2, 32'h10, 32'h0000AA00, 2, 32'h0, 1'b0);
    applyStimulus(1, 4'h0, 32'h10, 32'h0,        2, 32'hDEADAAEF, 1'b0);
    applyStimulus(1, 4'hF, 32'h30, 32'h5A5A5A5A, 2, 32'h0, 1'b1);
    applyStimulus(1, 4'h0, 32'h30, 32'h0,        2, 32'h5A5A5A5A, 1'b0);
    idleCycles(1, 1);

    // Three wait states with a reset landing in the first BUSY cycle of a write
    applyStimulus(2, 4'hF, 32'h20, 32'h11223344, 3, 32'h0, 1'b0);
    applyStimulus(2, 4'h0, 32'h20, 32'h0,        3, 32'h11223344, 1'b0);
    @(negedge clk);
    en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'hFFFFFFFF;
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0; en[2] = 1'b0; wen[2] = 4'd0;
    #1;
    checkOutput("abort_rdata_dut2", rdata[2], 32'd0);
    checkOutput("abort_stall_dut2", {31'd0, stall[2]}, 32'd0);
    applyStimulus(2, 4'h0, 32'h20, 32'h0, 3, 32'h11223344, 1'b0);
    idleCycles(2, 3);

    repeat (3) @(negedge clk);
    checkOutput("pending_dut0", exp_q0.size(), 32'd0);
    checkOutput("pending_dut1", exp_q1.size(), 32'd0);
    checkOutput("pending_dut2", exp_q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
